// File: rtl/pwm_multi_if.sv
// Control and output bundle for pwm_multi: enable, packed speed codes and
// polarity in; registered PWM pins and period strobe out.
interface pwm_multi_if #(
   parameter int CH = 2,
   parameter int SW = 5
);
   logic              en;
   logic [CH*SW-1:0]  speed;
   logic [CH-1:0]     pol;
   logic [CH-1:0]     pwm_out;
   logic              period_tick;

   modport master (output en, speed, pol, input pwm_out, period_tick);
   modport slave  (input en, speed, pol, output pwm_out, period_tick);
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel motor PWM: shared period counter, per-channel shadowed duty,
// polarity and period strobe. Optional duty ramping via `define PWM_RAMP_EN.
module pwm_multi #(
   parameter int CH     = 2,
   parameter int CW     = 8,
   parameter int PERIOD = 256,
   parameter int SW     = 5,
   parameter int BASE   = 120,
   parameter int STEP   = 8,
   parameter int RAMP   = 16
) (
   input  logic       clk,
   input  logic       rst,
   pwm_multi_if.slave bus
);
   localparam int TW = CW + SW + 2;
   localparam int DW = CW + 1;
   localparam logic [CW-1:0] LAST  = CW'(PERIOD - 1);
   localparam logic [TW-1:0] PER_T = TW'(PERIOD);
   localparam logic [DW-1:0] PER_D = DW'(PERIOD);

   generate
      if (PERIOD < 2 || PERIOD > (1 << CW) || RAMP < 1) begin : g_bad_param
         $error("pwm_multi: illegal PERIOD/CW/RAMP combination");
      end
   endgenerate

   logic [CW-1:0] cnt;
   logic [DW-1:0] duty_act [CH];
   logic [DW-1:0] duty_nxt [CH];
   logic [CH-1:0] pwm_p1;
   logic          tick_p1;
   logic          wrap;
   logic          load;

   function automatic logic [DW-1:0] tgt_duty(input logic [SW-1:0] s);
      logic [TW-1:0] raw;
      raw = TW'(BASE) + TW'(s) * TW'(STEP);
      if (s == '0)
         return '0;
      if (raw > PER_T)
         return PER_D;
      return DW'(raw);
   endfunction

`ifdef PWM_RAMP_EN
   function automatic logic [DW-1:0] ramp_step(input logic [DW-1:0] cur,
                                               input logic [DW-1:0] tgt);
      logic signed [DW+1:0] diff;
      logic signed [DW+1:0] lim;
      diff = signed'({2'b00, tgt}) - signed'({2'b00, cur});
      lim  = (DW+2)'(RAMP);
      if (diff > lim)
         return cur + DW'(RAMP);
      if (diff < -lim)
         return cur - DW'(RAMP);
      return tgt;
   endfunction
`endif

   assign wrap = bus.en && (cnt == LAST);
   assign load = wrap || !bus.en;

   // While disabled the shadow tracks the target (or zero when ramping) so
   // the first enabled period already runs at the loaded duty.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
`ifdef PWM_RAMP_EN
         duty_nxt[i] = bus.en ? ramp_step(duty_act[i], tgt_duty(bus.speed[i*SW +: SW])) : '0;
`else
         duty_nxt[i] = tgt_duty(bus.speed[i*SW +: SW]);
`endif
      end
   end

   // Stage p0 -> p1: counter compare registered onto the pins
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         tick_p1  <= 1'b0;
         pwm_p1   <= '0;
         duty_act <= '{default: '0};
      end else begin
         cnt     <= load ? '0 : cnt + 1'b1;
         tick_p1 <= wrap;
         for (int i = 0; i < CH; i++) begin
            if (load)
               duty_act[i] <= duty_nxt[i];
            pwm_p1[i] <= (bus.en && ({1'b0, cnt} < duty_act[i])) ^ bus.pol[i];
         end
      end
   end

   assign bus.pwm_out     = pwm_p1;
   assign bus.period_tick = tick_p1;
endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: per-cycle reference model pushes expected
// pins into a queue, a monitor pops and compares after each rising edge.
module tb_pwm_multi;
   localparam int CH = 2, CW = 8, PERIOD = 256, SW = 5, BASE = 120, STEP = 8, RAMP = 16;

   typedef struct packed {
      logic [CH-1:0] out;
      logic          tick;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   fails  = 0;
   exp_t q[$];
   int   pos;
   int   duty [CH];

   always #5 clk = ~clk;

   pwm_multi_if #(.CH(CH), .SW(SW)) bus ();

   pwm_multi #(.CH(CH), .CW(CW), .PERIOD(PERIOD), .SW(SW), .BASE(BASE),
               .STEP(STEP), .RAMP(RAMP)) dut (.clk(clk), .rst(rst), .bus(bus));

   function automatic int tgt_of(int s);
      int v;
      if (s == 0) return 0;
      v = BASE + s * STEP;
      return (v > PERIOD) ? PERIOD : v;
   endfunction

   function automatic int next_duty(int cur, int tgt, bit enabled);
`ifdef PWM_RAMP_EN
      if (!enabled) return 0;
      if (tgt - cur > RAMP) return cur + RAMP;
      if (cur - tgt > RAMP) return cur - RAMP;
      return tgt;
`else
      return tgt;
`endif
   endfunction

   task automatic model_reset();
      pos = 0;
      for (int i = 0; i < CH; i++) duty[i] = 0;
   endtask

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Predict the pins after the coming rising edge, then advance one clock.
   task automatic cyc();
      exp_t e;
      logic [CH*SW-1:0] sp;
      bit en_v;
      sp   = bus.speed;
      en_v = bus.en;
      for (int i = 0; i < CH; i++)
         e.out[i] = logic'(en_v && pos < duty[i]) ^ bus.pol[i];
      e.tick = en_v && (pos == PERIOD - 1);
      q.push_back(e);
      if (!en_v || pos == PERIOD - 1) begin
         for (int i = 0; i < CH; i++)
            duty[i] = next_duty(duty[i], tgt_of(int'(sp[i*SW +: SW])), en_v);
         pos = 0;
      end else begin
         pos++;
      end
      @(negedge clk);
   endtask

   task automatic run_period(input int chg_at, input logic [SW-1:0] chg_spd,
                             output int hi0, output int hi1, output int ticks);
      hi0 = 0; hi1 = 0; ticks = 0;
      for (int k = 0; k < PERIOD; k++) begin
         if (k == chg_at) bus.speed[SW-1:0] = chg_spd;
         cyc();
         hi0   += int'(bus.pwm_out[0]);
         hi1   += int'(bus.pwm_out[1]);
         ticks += int'(bus.period_tick);
      end
   endtask

   task automatic async_reset(string name);
      rst = 1'b0;
      #1;
      chk({name, "_pwm"}, int'(bus.pwm_out), 0);
      chk({name, "_tick"}, int'(bus.period_tick), 0);
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (bus.pwm_out !== e.out || bus.period_tick !== e.tick) begin
            fails++;
            $display("FAIL sb t=%0t pwm_out=%b tick=%b expected pwm_out=%b tick=%b",
                     $time, bus.pwm_out, bus.period_tick, e.out, e.tick);
         end
      end
   end

   initial begin
      int h0, h1, tk;
      bus.en    = 1'b0;
      bus.speed = '0;
      bus.pol   = '0;
      model_reset();
      #2;
      async_reset("reset");

      bus.speed = {5'd0, 5'd5};
      cyc(); cyc();
      bus.en = 1'b1;
`ifndef PWM_RAMP_EN
      for (int p = 0; p < 2; p++) begin
         run_period(-1, '0, h0, h1, tk);
         chk("spd5_hi0", h0, 160);
         chk("spd5_hi1", h1, 0);
         chk("spd5_ticks", tk, 1);
      end

      bus.speed = {5'd0, 5'd31};
      run_period(-1, '0, h0, h1, tk);
      run_period(-1, '0, h0, h1, tk);
      chk("clamp_hi0", h0, 256);
      chk("clamp_hi1", h1, 0);
      run_period(-1, '0, h0, h1, tk);
      chk("clamp_hi0_2", h0, 256);

      bus.speed = {5'd0, 5'd5};
      run_period(-1, '0, h0, h1, tk);
      run_period(50, 5'd10, h0, h1, tk);
      chk("midchg_cur", h0, 160);
      run_period(-1, '0, h0, h1, tk);
      chk("midchg_next", h0, 200);

      bus.speed = {5'd0, 5'd5};
      run_period(-1, '0, h0, h1, tk);
      bus.pol = 2'b01;
      run_period(-1, '0, h0, h1, tk);
      chk("pol_hi0", h0, 96);
      chk("pol_hi1", h1, 0);
      bus.en = 1'b0;
      cyc();
      chk("dis_pwm", int'(bus.pwm_out), 1);
      chk("dis_tick", int'(bus.period_tick), 0);
      cyc();
      chk("dis_tick2", int'(bus.period_tick), 0);

      bus.pol = 2'b00;
      bus.en  = 1'b1;
      repeat (100) cyc();
      async_reset("midrst");
      run_period(-1, '0, h0, h1, tk);
      chk("post_rst_hi0", h0, 0);
      chk("post_rst_ticks", tk, 1);
      run_period(-1, '0, h0, h1, tk);
      chk("post_rst_hi0_2", h0, 160);
`else
      for (int p = 0; p < 12; p++) begin
         run_period(-1, '0, h0, h1, tk);
         chk($sformatf("ramp_p%0d", p), h0, (16 * p > 160) ? 160 : 16 * p);
         chk($sformatf("ramp_tick%0d", p), tk, 1);
      end
`endif

      for (int n = 0; n < 6000; n++) begin
         if ($urandom_range(0, 59) == 0) begin
            for (int i = 0; i < CH; i++) begin
               case ($urandom_range(0, 3))
                  0:       bus.speed[i*SW +: SW] = '0;
                  1:       bus.speed[i*SW +: SW] = '1;
                  default: bus.speed[i*SW +: SW] = SW'($urandom);
               endcase
            end
         end
         if ($urandom_range(0, 399) == 0) bus.pol = CH'($urandom);
         if ($urandom_range(0, 699) == 0) bus.en = ~bus.en;
         if (n == 3000) async_reset("rnd_rst");
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
